// File: rtl/conv_maxpool_2x2.sv
// conv_maxpool_2x2
// Streaming 2x2 max-pool, stride 1, for a DIM x DIM row-major OFM stream.
// A pooled value is emitted one cycle after the element that completes its
// window. The frame boundary is implied by the row/column counters wrapping.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   in_valid  In_OFM carries one element this cycle
//   In_OFM    input element (unsigned, DATA_W bits)
//   out_valid Out_Pool valid this cycle (registered)
//   Out_Pool  pooled maximum, 0 when out_valid is low (registered)
//   out_last  marks the final pooled output of a frame (registered)
module conv_maxpool_2x2 #(
    parameter int DATA_W = 36,
    parameter int DIM    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] In_OFM,
    output logic              out_valid,
    output logic [DATA_W-1:0] Out_Pool,
    output logic              out_last
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);
    localparam logic [CW-1:0] IDX_ONE  = CW'(1);
    localparam logic [CW-1:0] IDX_ZERO = CW'(0);

    logic [CW-1:0]     row_r;
    logic [CW-1:0]     col_r;
    logic [DATA_W-1:0] lb_r [DIM];
    // previous element of the current row (left neighbour)
    logic [DATA_W-1:0] prev_r;
    // previous-row value at column c-1 (top-left neighbour). The line buffer
    // slot c-1 already holds the current row by the time column c arrives,
    // so its old content is captured here when it is read.
    logic [DATA_W-1:0] diag_r;

    logic              out_valid_r;
    logic [DATA_W-1:0] pool_r;
    logic              out_last_r;

    logic              col_last_s;
    logic              row_last_s;
    logic              win_s;
    logic [DATA_W-1:0] up_s;
    logic [DATA_W-1:0] max_s;

    // unsigned full-width maximum of two values
    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // window detection and four-way maximum of the current window
    always_comb begin
        col_last_s = (col_r == LAST_IDX);
        row_last_s = (row_r == LAST_IDX);
        win_s      = (row_r != IDX_ZERO) && (col_r != IDX_ZERO);
        up_s       = lb_r[col_r];
        max_s      = max2(max2(diag_r, up_s), max2(prev_r, In_OFM));
    end

    // position counters, line buffer and neighbour registers
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r  <= IDX_ZERO;
            col_r  <= IDX_ZERO;
            prev_r <= '0;
            diag_r <= '0;
            for (int i = 0; i < DIM; i++) begin
                lb_r[i] <= '0;
            end
        end else if (in_valid) begin
            diag_r       <= up_s;
            prev_r       <= In_OFM;
            lb_r[col_r]  <= In_OFM;
            if (col_last_s) begin
                col_r <= IDX_ZERO;
                if (row_last_s) begin
                    row_r <= IDX_ZERO;
                end else begin
                    row_r <= row_r + IDX_ONE;
                end
            end else begin
                col_r <= col_r + IDX_ONE;
            end
        end else begin
            row_r  <= row_r;
            col_r  <= col_r;
            prev_r <= prev_r;
            diag_r <= diag_r;
        end
    end

    // registered outputs; data and last are forced to zero when not valid
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            pool_r      <= '0;
            out_last_r  <= 1'b0;
        end else if (in_valid && win_s) begin
            out_valid_r <= 1'b1;
            pool_r      <= max_s;
            out_last_r  <= col_last_s && row_last_s;
        end else begin
            out_valid_r <= 1'b0;
            pool_r      <= '0;
            out_last_r  <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign Out_Pool  = pool_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_conv_maxpool_2x2.sv
// Testbench for conv_maxpool_2x2: directed test-plan frames plus random
// frames with random gaps, checked cycle by cycle against a 2-D frame model.
module tb_conv_maxpool_2x2;

    localparam int DW  = 36;
    localparam int DIM = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] In_OFM;
    logic          out_valid;
    logic [DW-1:0] Out_Pool;
    logic          out_last;

    conv_maxpool_2x2 #(.DATA_W(DW), .DIM(DIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .In_OFM    (In_OFM),
        .out_valid (out_valid),
        .Out_Pool  (Out_Pool),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // model: frame stored as a 2-D array, k = accepted elements this frame
    logic [DW-1:0] fr [DIM][DIM];
    int            k = 0;
    logic          cap = 1'b0;
    logic [DW-1:0] got [$];
    logic [DW-1:0] all_ones;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mx(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // one clock cycle: drive, advance the model, check outputs after the edge
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        int            rr;
        int            cc;
        @(negedge clk);
        rst = r; in_valid = v; In_OFM = d;
        ev = 1'b0; ed = '0; el = 1'b0;
        if (r) begin
            k = 0;
        end else if (v) begin
            rr = k / DIM;
            cc = k % DIM;
            fr[rr][cc] = d;
            if (rr >= 1 && cc >= 1) begin
                ev = 1'b1;
                ed = mx(mx(fr[rr-1][cc-1], fr[rr-1][cc]), mx(fr[rr][cc-1], fr[rr][cc]));
                el = (rr == DIM-1) && (cc == DIM-1);
            end
            k = (k + 1) % (DIM*DIM);
        end
        @(posedge clk);
        #1;
        check("out_valid", {35'd0, out_valid}, {35'd0, ev});
        check("Out_Pool", Out_Pool, ed);
        check("out_last", {35'd0, out_last}, {35'd0, el});
        if (cap && out_valid) got.push_back(Out_Pool);
    endtask

    task automatic ramp_up();
        for (int i = 1; i <= DIM*DIM; i++) step(1'b1, DW'(i), 1'b0);
    endtask

    initial begin
        logic [DW-1:0] asc [16];
        logic [DW-1:0] v;
        asc = '{36'd7, 36'd8, 36'd9, 36'd10, 36'd12, 36'd13, 36'd14, 36'd15,
                36'd17, 36'd18, 36'd19, 36'd20, 36'd22, 36'd23, 36'd24, 36'd25};
        all_ones = '1;
        rst = 1'b1; in_valid = 1'b0; In_OFM = '0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) fr[i][j] = '0;

        // reset state
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // ascending ramp, also compared against the literal expected list
        cap = 1'b1;
        ramp_up();
        step(1'b0, '0, 1'b0);
        cap = 1'b0;
        check("asc_count", DW'(got.size()), 36'd16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("asc_value", got[i], asc[i]);
        got.delete();

        // descending ramp
        for (int i = DIM*DIM; i >= 1; i--) step(1'b1, DW'(i), 1'b0);
        step(1'b0, '0, 1'b0);

        // gapped ascending ramp: 3 idle cycles after elements 4, 11, 20
        cap = 1'b1;
        for (int i = 1; i <= DIM*DIM; i++) begin
            step(1'b1, DW'(i), 1'b0);
            if (i == 4 || i == 11 || i == 20)
                for (int g = 0; g < 3; g++) step(1'b0, DW'($urandom), 1'b0);
        end
        cap = 1'b0;
        check("gap_count", DW'(got.size()), 36'd16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("gap_value", got[i], asc[i]);
        got.delete();

        // back-to-back: ascending then all-ones with no idle gap
        ramp_up();
        for (int i = 0; i < DIM*DIM; i++) step(1'b1, all_ones, 1'b0);
        step(1'b0, '0, 1'b0);

        // reset after 10 elements, then a fresh ascending frame
        for (int i = 1; i <= 10; i++) step(1'b1, DW'(i * 1000), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        cap = 1'b1;
        ramp_up();
        cap = 1'b0;
        check("rst_count", DW'(got.size()), 36'd16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("rst_value", got[i], asc[i]);
        got.delete();

        // single hot element (2,2) = 1000
        for (int i = 0; i < DIM*DIM; i++)
            step(1'b1, (i == 2*DIM+2) ? 36'd1000 : 36'd0, 1'b0);
        step(1'b0, '0, 1'b0);

        // random frames, random values and random gaps
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < DIM*DIM; i++) begin
                while ($urandom_range(0, 3) == 0) step(1'b0, DW'($urandom), 1'b0);
                v = {$urandom, $urandom};
                if ($urandom_range(0, 4) == 0) v = all_ones;
                if ($urandom_range(0, 4) == 0) v = '0;
                step(1'b1, v, 1'b0);
            end
        end
        step(1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // global timeout guard
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_maxpool_2x2.md
Name: conv_maxpool_2x2

Overview:
- Streaming 2x2 max-pool stage, stride 1, placed directly downstream of the 7x7-IFM / 3x3-weight convolution block.
- Consumes the convolution's serial 5x5 OFM stream: 25 row-major 36-bit values qualified by the upstream out_valid.
- Emits the 4x4 pooled map: 16 row-major values, each the max of one 2x2 window.
- Uses a one-row line buffer plus a previous-pixel register, so a pooled value is produced as soon as its window completes.

Parameters:
- DATA_W, 36, width of input OFM values and pooled outputs (unsigned).
- DIM, 5, side of the square input map; output side is DIM-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  In_OFM carries one OFM element this cycle (driven by the upstream out_valid)
- In_OFM  input  DATA_W  OFM element, row-major, unsigned
- out_valid  output  1  Out_Pool is valid this cycle (registered)
- Out_Pool  output  DATA_W  pooled maximum (registered)
- out_last  output  1  high together with out_valid on the 16th (final) output of a frame (registered)

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: out_valid=0, Out_Pool=0, out_last=0. Row/column counters=0. Line buffer and previous-pixel register=0.
- Reset mid-frame: the partial frame is discarded. The next accepted element is treated as element (0,0).
- Input indexing:
  - col counter 0..DIM-1 and row counter 0..DIM-1 advance only on cycles where in_valid=1.
  - col wraps to 0 after DIM-1 and increments row.
  - After element (DIM-1,DIM-1) both counters return to 0. A new frame may begin on the very next cycle with no idle gap.
- Gaps: in_valid may drop anywhere within a frame. The counters and all stored data hold, and no output is produced during the gap.
- Storage:
  - line buffer LB[0..DIM-1] holds the previous row.
  - On each accepted element at column c: LB[c] is overwritten with the new value only after its old value has been read for the window compare.
  - prev holds the previous element of the current row.
- Window compare on accepted element (r,c) with r>=1 and c>=1:
  - max of LB[c-1], LB[c], prev, In_OFM.
  - unsigned compare, full DATA_W width, no truncation.
- Output timing:
  - out_valid=1 and Out_Pool=that max on the cycle after the accepted element (latency 1).
  - Window index = (r-1)*(DIM-1)+(c-1).
  - No output for elements with r=0 or c=0.
- Output when idle: whenever out_valid=0, Out_Pool=0 and out_last=0.
- Output count: exactly (DIM-1)^2 = 16 pulses per complete frame. out_last accompanies the pulse for window (DIM-2,DIM-2).
- Equal values: the result is the common value; no tie-break is needed.
- Frame state: no FSM states beyond the counters. The frame boundary is implied by the counter wrap, and out_last is derived from the wrap condition.

Test Plan:
- Ascending ramp: 25 contiguous inputs with values 1..25 -> 16 contiguous outputs 7,8,9,10,12,13,14,15,17,18,19,20,22,23,24,25. First out_valid is one cycle after input 7 is accepted; out_last is high with value 25.
- Descending ramp: 25 contiguous inputs with values 25..1 -> outputs 25,24,23,22,20,19,18,17,15,14,13,12,10,9,8,7.
- Gapped stream: the ascending frame with in_valid low for 3 cycles after elements 4, 11 and 20 -> same 16 values. Each output appears exactly one cycle after its completing input, and there are no outputs during the gaps.
- Back-to-back frames: ascending frame immediately followed by a frame whose inputs are all 68719476735 (2^36-1) -> first 16 outputs as in the ascending case. Second frame gives 16 outputs of 68719476735 with out_last on its 16th output. No cross-frame contamination: the second frame's first output waits for its own element (1,1).
- Reset mid-frame: assert rst for 1 cycle after 10 elements have been accepted, then send the ascending frame -> outputs are all 0 during and after reset until the new frame. The new frame yields exactly the ascending-ramp sequence.
- Single hot element: all zeros except element (2,2)=1000 -> outputs at window indices 5, 6, 9 and 10 equal 1000; all other outputs are 0.
